// File: rtl/wb_bus_if_n.sv
`default_nettype none
// ============================================================================
// Module : wb_bus_if_n
// Desc   : Wishbone-classic slave front end: region decode, read-data mux,
//          single pop/write strobe per transfer, wait states for FIFO reads.
// Rev    : 1.0 - initial release
// ============================================================================
module wb_bus_if_n #(
   parameter int                              DATA_W        = 8,
   parameter int                              ADDR_W        = 8,
   parameter int                              REGION_BITS   = 4,
   parameter logic [(2**REGION_BITS)-1:0]     SLOW_RD_MASK  = 16'h3FCC,
   parameter logic [(2**REGION_BITS)-1:0]     UNMAPPED_MASK = 16'h8000,
   parameter int                              WAIT_CYCLES   = 1
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     cyc_i,
   input  logic                                     stb_i,
   input  logic                                     we_i,
   input  logic [ADDR_W-1:0]                        adr_i,
   input  logic [DATA_W-1:0]                        dat_i,
   output logic [DATA_W-1:0]                        dat_o,
   output logic                                     ack_o,
   output logic                                     err_o,
   output logic [(2**REGION_BITS)-1:0]              sel_o,
   output logic                                     wr_stb_o,
   output logic                                     rd_stb_o,
   input  logic [(2**REGION_BITS)*DATA_W-1:0]       region_data_i
);

   localparam logic [3:0] C_WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2,
      S_ERR  = 2'd3
   } state_t;

   state_t                         r_state;
   state_t                         w_next;
   logic [3:0]                     r_cnt;
   logic [3:0]                     w_cnt_next;
   logic [DATA_W-1:0]              r_dat;
   logic [DATA_W-1:0]              w_rd_slice;
   logic                           w_load_dat;
   logic [REGION_BITS-1:0]         w_region;
   logic [ADDR_W-REGION_BITS-1:0]  w_offset;
   logic                           w_req;
   logic                           w_mapped;
   logic                           w_slow;
   logic                           w_unused_dat;

   // Write data goes straight to the regions; nothing here consumes it.
   assign w_unused_dat = ^dat_i;

   assign w_region   = adr_i[ADDR_W-1 -: REGION_BITS];
   assign w_offset   = adr_i[ADDR_W-REGION_BITS-1:0];
   assign w_req      = cyc_i & stb_i;
   assign w_mapped   = ~UNMAPPED_MASK[w_region];
   assign w_slow     = ~we_i & SLOW_RD_MASK[w_region] & (w_offset == '0);
   assign w_rd_slice = region_data_i[w_region*DATA_W +: DATA_W];

   always_comb begin
      sel_o = '0;
      if (w_req && w_mapped) begin
         sel_o[w_region] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_dat   <= '0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_load_dat) begin
            r_dat <= w_rd_slice;
         end
      end
   end

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      w_load_dat = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_req) begin
               if (!w_mapped) begin
                  w_next = S_ERR;
               end else if (w_slow) begin
                  w_cnt_next = C_WAIT_LOAD;
                  w_next     = S_WAIT;
               end else begin
                  w_next     = S_RESP;
                  w_load_dat = ~we_i;
               end
            end
         end
         S_WAIT: begin
            // An abandoned pop is simply dropped; the FIFO already advanced.
            if (!w_req) begin
               w_next = S_IDLE;
            end else if (r_cnt == 4'd0) begin
               w_next     = S_RESP;
               w_load_dat = ~we_i;
            end else begin
               w_cnt_next = r_cnt - 4'd1;
            end
         end
         S_RESP:  w_next = S_IDLE;
         S_ERR:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   assign dat_o    = r_dat;
   assign ack_o    = (r_state == S_RESP);
   assign err_o    = (r_state == S_ERR);
   assign wr_stb_o = (r_state == S_RESP) & we_i;
   // Gated by reset so a master holding req through reset sees no pop.
   assign rd_stb_o = rst & (r_state == S_IDLE) & w_req & w_slow & w_mapped;

endmodule
`default_nettype wire

// File: tb/tb_wb_bus_if_n.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for wb_bus_if_n: three instances (WAIT_CYCLES 1..3), table vectors,
// scoreboard of expected responses, hand sequences for abort/reset/streaming.
module tb_wb_bus_if_n;

   localparam int DW = 8;
   localparam int NR = 16;
   localparam int ND = 3;
   localparam logic [15:0] UNMAP_MASK = 16'h8000;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic             cyc_a [ND];
   logic             stb_a [ND];
   logic             we_a  [ND];
   logic [7:0]       adr_a [ND];
   logic [7:0]       wdat_a[ND];
   logic [7:0]       dat_a [ND];
   logic             ack_a [ND];
   logic             err_a [ND];
   logic             wr_a  [ND];
   logic             rd_a  [ND];
   logic [15:0]      sel_a [ND];
   logic [NR*DW-1:0] region_data;

   for (genvar g = 0; g < ND; g++) begin : g_dut
      wb_bus_if_n #(.WAIT_CYCLES(g + 1)) u_dut (
         .clk           (clk),
         .rst           (rst),
         .cyc_i         (cyc_a[g]),
         .stb_i         (stb_a[g]),
         .we_i          (we_a[g]),
         .adr_i         (adr_a[g]),
         .dat_i         (wdat_a[g]),
         .dat_o         (dat_a[g]),
         .ack_o         (ack_a[g]),
         .err_o         (err_a[g]),
         .sel_o         (sel_a[g]),
         .wr_stb_o      (wr_a[g]),
         .rd_stb_o      (rd_a[g]),
         .region_data_i (region_data)
      );
   end

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] rdat(input int r);
      if (r == 2) return 8'h5C;
      return 8'(8'h11 * r + 8'h03);
   endfunction

   function automatic logic [15:0] exp_sel(input logic [7:0] adr);
      logic [15:0] m;
      logic [15:0] s;
      m = UNMAP_MASK;
      s = '0;
      if (!m[adr[7:4]]) s[adr[7:4]] = 1'b1;
      return s;
   endfunction

   typedef struct {
      int         dut;
      logic       err;
      logic [7:0] dat;
   } exp_t;

   exp_t       sb_q[$];
   logic [7:0] last_dat[ND];

   task automatic push_exp(input int d, input logic we, input logic [7:0] adr, input logic err);
      exp_t e;
      e.dut = d;
      e.err = err;
      e.dat = (!we && !err) ? rdat(int'(adr[7:4])) : last_dat[d];
      last_dat[d] = e.dat;
      sb_q.push_back(e);
   endtask

   always @(negedge clk) begin : p_mon
      exp_t e;
      for (int d = 0; d < ND; d++) begin
         if (ack_a[d] || err_a[d]) begin
            if (sb_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_unexpected dut%0d: got ack=%b err=%b expected no response",
                        d, ack_a[d], err_a[d]);
            end else begin
               e = sb_q.pop_front();
               chk("sb_dut", d, e.dut);
               chk("sb_err", int'(err_a[d]), int'(e.err));
               chk("sb_ack", int'(ack_a[d]), int'(!e.err));
               chk("sb_dat", int'(dat_a[d]), int'(e.dat));
            end
         end
      end
   end

   task automatic drive(input int d, input logic we, input logic [7:0] adr, input logic [7:0] wd);
      @(posedge clk); #1;
      cyc_a[d]  = 1'b1;
      stb_a[d]  = 1'b1;
      we_a[d]   = we;
      adr_a[d]  = adr;
      wdat_a[d] = wd;
   endtask

   task automatic release_bus(input int d);
      @(posedge clk); #1;
      cyc_a[d] = 1'b0;
      stb_a[d] = 1'b0;
      we_a[d]  = 1'b0;
   endtask

   task automatic wait_resp(input int d, input logic [7:0] adr, input logic we, input int lat,
                            input logic err, input logic pop, input string nm);
      int   n;
      int   pops;
      int   wrs;
      logic done;
      n = 0; pops = 0; wrs = 0; done = 1'b0;
      while (!done && n < 20) begin
         @(negedge clk);
         chk({nm, " sel"}, int'(sel_a[d]), int'(exp_sel(adr)));
         pops += int'(rd_a[d]);
         wrs  += int'(wr_a[d]);
         if (ack_a[d] || err_a[d]) begin
            done = 1'b1;
            chk({nm, " wr_at_resp"}, int'(wr_a[d]), int'(we && !err));
         end else begin
            n++;
         end
      end
      chk({nm, " responded"}, int'(done), 1);
      if (!done) begin
         void'(sb_q.pop_back());
      end else begin
         chk({nm, " latency"}, n, lat);
      end
      chk({nm, " pops"}, pops, int'(pop));
      chk({nm, " writes"}, wrs, int'(we && !err));
   endtask

   typedef struct {
      int         dut;
      logic       we;
      logic [7:0] adr;
      logic [7:0] wdat;
      int         lat;
      logic       err;
      logic       pop;
   } vec_t;

   vec_t vecs[11];

   initial begin : p_watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin : p_main
      int acks;
      int pops;
      vecs[0]  = '{0, 1'b1, 8'h42, 8'hA5, 1, 1'b0, 1'b0};
      vecs[1]  = '{0, 1'b0, 8'h20, 8'h00, 2, 1'b0, 1'b1};
      vecs[2]  = '{0, 1'b0, 8'h21, 8'h00, 1, 1'b0, 1'b0};
      vecs[3]  = '{2, 1'b0, 8'h60, 8'h00, 4, 1'b0, 1'b1};
      vecs[4]  = '{0, 1'b0, 8'hF0, 8'h00, 1, 1'b1, 1'b0};
      vecs[5]  = '{0, 1'b1, 8'hF0, 8'h3C, 1, 1'b1, 1'b0};
      vecs[6]  = '{1, 1'b0, 8'h10, 8'h00, 1, 1'b0, 1'b0};
      vecs[7]  = '{1, 1'b0, 8'h70, 8'h00, 3, 1'b0, 1'b1};
      vecs[8]  = '{0, 1'b1, 8'h20, 8'h11, 1, 1'b0, 1'b0};
      vecs[9]  = '{0, 1'b0, 8'h95, 8'h00, 1, 1'b0, 1'b0};
      vecs[10] = '{2, 1'b0, 8'hF3, 8'h00, 1, 1'b1, 1'b0};

      for (int r = 0; r < NR; r++) region_data[r*DW +: DW] = rdat(r);
      rst = 1'b0;
      for (int d = 0; d < ND; d++) begin
         cyc_a[d] = 1'b0; stb_a[d] = 1'b0; we_a[d] = 1'b0;
         adr_a[d] = '0; wdat_a[d] = '0; last_dat[d] = '0;
      end

      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < ND; d++) begin
         chk("reset dat", int'(dat_a[d]), 0);
         chk("reset ack", int'(ack_a[d]), 0);
         chk("reset err", int'(err_a[d]), 0);
         chk("reset wr",  int'(wr_a[d]), 0);
         chk("reset rd",  int'(rd_a[d]), 0);
         chk("reset sel", int'(sel_a[d]), 0);
      end
      rst = 1'b1;

      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].dut, vecs[i].we, vecs[i].adr, vecs[i].wdat);
         push_exp(vecs[i].dut, vecs[i].we, vecs[i].adr, vecs[i].err);
         wait_resp(vecs[i].dut, vecs[i].adr, vecs[i].we, vecs[i].lat,
                   vecs[i].err, vecs[i].pop, $sformatf("vec%0d", i));
         release_bus(vecs[i].dut);
         repeat (2) @(posedge clk);
      end

      // Abort a slow read mid-wait on the WAIT_CYCLES=2 instance.
      drive(1, 1'b0, 8'h30, 8'h00);
      @(negedge clk);
      chk("abort pop_at_T", int'(rd_a[1]), 1);
      @(posedge clk); #1;
      stb_a[1] = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("abort no_ack", int'(ack_a[1] | err_a[1]), 0);
         chk("abort no_pop", int'(rd_a[1]), 0);
         chk("abort dat_held", int'(dat_a[1]), int'(last_dat[1]));
      end
      release_bus(1);
      drive(1, 1'b0, 8'h10, 8'h00);
      push_exp(1, 1'b0, 8'h10, 1'b0);
      wait_resp(1, 8'h10, 1'b0, 1, 1'b0, 1'b0, "post_abort");
      release_bus(1);
      repeat (2) @(posedge clk);

      // Reset asserted while the WAIT_CYCLES=3 instance is waiting.
      drive(2, 1'b0, 8'h60, 8'h00);
      @(negedge clk);
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      chk("rst_mid dat", int'(dat_a[2]), 0);
      chk("rst_mid ack", int'(ack_a[2]), 0);
      chk("rst_mid err", int'(err_a[2]), 0);
      chk("rst_mid wr",  int'(wr_a[2]), 0);
      chk("rst_mid rd",  int'(rd_a[2]), 0);
      last_dat[2] = '0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      push_exp(2, 1'b0, 8'h60, 1'b0);
      wait_resp(2, 8'h60, 1'b0, 4, 1'b0, 1'b1, "rst_restart");
      release_bus(2);
      repeat (2) @(posedge clk);

      // Four fast reads with stb held: ack every second cycle.
      drive(0, 1'b0, 8'h95, 8'h00);
      for (int k = 0; k < 4; k++) push_exp(0, 1'b0, 8'h95, 1'b0);
      acks = 0;
      pops = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk($sformatf("stream ack c%0d", k), int'(ack_a[0]), k % 2);
         acks += int'(ack_a[0]);
         pops += int'(rd_a[0]);
      end
      release_bus(0);
      repeat (3) @(posedge clk);
      chk("stream acks", acks, 4);
      chk("stream pops", pops, 0);

      chk("sb_drained", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
